// File: rtl/tl_mem_slave.sv
// Purpose : TileLink-UL memory endpoint (Get / PutFullData / PutPartialData, wrapped bursts)
//           served from an internal 64-bit word RAM of DEPTH words.
// Latency : Get beat 0 one cycle after A acceptance, then one beat per D handshake;
//           AccessAck one cycle after the final Put beat.
// Backpressure: a_ready_o is high only in IDLE/WR; D outputs are registered and held while
//           d_valid_o && !d_ready_i.
// Ports   : clk_i/rst_ni (async active-low); A channel a_*_i with a_valid_i/a_ready_o;
//           D channel d_*_o with d_valid_o/d_ready_i.
module tl_mem_slave #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 4,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        a_opcode_i,
  input  logic [2:0]        a_param_i,
  input  logic [2:0]        a_size_i,
  input  logic [SRC_W-1:0]  a_source_i,
  input  logic [ADDR_W-1:0] a_address_i,
  input  logic [7:0]        a_mask_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  output logic [2:0]        d_opcode_o,
  output logic [1:0]        d_param_o,
  output logic [2:0]        d_size_o,
  output logic [SRC_W-1:0]  d_source_o,
  output logic [1:0]        d_sink_o,
  output logic              d_denied_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              d_corrupt_o,
  output logic              d_valid_o,
  input  logic              d_ready_i
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_ACK} state_t;

  state_t              r_state, w_next;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [SRC_W-1:0]    r_src;
  logic [2:0]          r_size;
  logic [IDX_W-1:0]    r_base;
  logic [2:0]          r_beat;   // WR: next beat to accept; RD: beat on D
  logic [2:0]          r_bmask;  // beats-1, also the wrap mask on the word index
  logic                r_denied;
  logic                r_corrupt;
  logic                r_d_valid;
  logic                r_d_opc;
  logic [DATA_W-1:0]   r_d_data;

  logic                w_a_ready;
  logic                w_a_fire;
  logic                w_d_fire;
  logic                w_op_get;
  logic                w_op_put;
  logic                w_req_oor;
  logic                w_req_denied;
  logic [IDX_W-1:0]    w_req_widx;
  logic [2:0]          w_req_bmask;
  logic                w_last;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [DATA_W-1:0]   w_rd_word;
  logic                w_we;
  logic [IDX_W-1:0]    w_we_idx;
  logic                w_unused;

  // Burst beats stay inside their naturally aligned block: only the low bits wrap.
  function automatic logic [IDX_W-1:0] beat_idx(input logic [IDX_W-1:0] base,
                                                input logic [2:0] bmask,
                                                input logic [2:0] k);
    logic [IDX_W-1:0] m;
    m = {{(IDX_W-3){1'b0}}, bmask};
    return (base & ~m) | ((base + {{(IDX_W-3){1'b0}}, k}) & m);
  endfunction

  assign w_unused     = ^{a_param_i, a_address_i[2:0]};
  assign w_a_fire     = a_valid_i & w_a_ready;
  assign w_d_fire     = r_d_valid & d_ready_i;
  assign w_op_get     = (a_opcode_i == 3'd4);
  assign w_op_put     = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
  assign w_req_oor    = |a_address_i[ADDR_W-1:3+IDX_W];
  assign w_req_denied = w_req_oor | ~(w_op_get | w_op_put);
  assign w_req_widx   = a_address_i[3 +: IDX_W];
  assign w_last       = (r_beat == r_bmask);
  assign w_wr_idx     = beat_idx(r_base, r_bmask, r_beat);
  assign w_rd_idx     = beat_idx(r_base, r_bmask, r_beat + 3'd1);
  // In IDLE the read port serves beat 0 of a new Get, otherwise the next burst beat.
  assign w_rd_word    = r_mem[(r_state == S_IDLE) ? w_req_widx : w_rd_idx];

  always_comb begin
    w_req_bmask = 3'd0;
    case (a_size_i)
      3'd4:       w_req_bmask = 3'd1;
      3'd5:       w_req_bmask = 3'd3;
      3'd6, 3'd7: w_req_bmask = 3'd7;
      default:    w_req_bmask = 3'd0;
    endcase
  end

  // Single write port shared by the first Put beat (IDLE) and later beats (WR).
  always_comb begin
    w_we     = 1'b0;
    w_we_idx = w_req_widx;
    if (r_state == S_IDLE) begin
      w_we = w_a_fire & ~w_req_denied & w_op_put;
    end else if (r_state == S_WR) begin
      w_we     = w_a_fire & ~r_denied;
      w_we_idx = w_wr_idx;
    end
  end

  // RAM has no reset: contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (w_we) begin
      for (int b = 0; b < 8; b++) begin
        if (a_mask_i[b]) r_mem[w_we_idx][8*b +: 8] <= a_data_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_a_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_a_ready = 1'b1;
        if (w_a_fire) begin
          if (w_op_get)                         w_next = S_RD;
          else if (w_op_put && w_req_bmask != 3'd0) w_next = S_WR;
          else                                  w_next = S_ACK;
        end
      end
      S_WR: begin
        w_a_ready = 1'b1;
        if (w_a_fire && w_last) w_next = S_ACK;
      end
      S_RD:  if (w_d_fire && w_last) w_next = S_IDLE;
      S_ACK: if (w_d_fire)           w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_src     <= '0;
      r_size    <= 3'd0;
      r_base    <= '0;
      r_beat    <= 3'd0;
      r_bmask   <= 3'd0;
      r_denied  <= 1'b0;
      r_corrupt <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_opc   <= 1'b0;
      r_d_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_a_fire) begin
          r_src     <= a_source_i;
          r_size    <= a_size_i;
          r_base    <= w_req_widx;
          r_denied  <= w_req_denied;
          r_bmask   <= (w_op_get | w_op_put) ? w_req_bmask : 3'd0;
          r_corrupt <= w_op_get & w_req_denied;
          if (w_op_get) begin
            r_beat    <= 3'd0;
            r_d_valid <= 1'b1;
            r_d_opc   <= 1'b1;
            r_d_data  <= w_req_denied ? '0 : w_rd_word;
          end else begin
            r_beat    <= 3'd1;
            r_d_opc   <= 1'b0;
            r_d_data  <= '0;
            r_d_valid <= (w_next == S_ACK);
          end
        end
        S_WR: if (w_a_fire) begin
          r_beat <= r_beat + 3'd1;
          if (w_last) r_d_valid <= 1'b1;
        end
        S_RD: if (w_d_fire) begin
          if (w_last) begin
            r_d_valid <= 1'b0;
          end else begin
            r_beat   <= r_beat + 3'd1;
            r_d_data <= r_denied ? '0 : w_rd_word;
          end
        end
        S_ACK: if (w_d_fire) r_d_valid <= 1'b0;
        default: r_d_valid <= 1'b0;
      endcase
    end
  end

  assign a_ready_o   = w_a_ready;
  assign d_valid_o   = r_d_valid;
  assign d_opcode_o  = {2'b00, r_d_opc};
  assign d_param_o   = 2'd0;
  assign d_size_o    = r_size;
  assign d_source_o  = r_src;
  assign d_sink_o    = 2'd0;
  assign d_denied_o  = r_denied;
  assign d_corrupt_o = r_corrupt;
  assign d_data_o    = r_d_data;

endmodule

// File: doc/tl_mem_slave.md
# tl_mem_slave

TileLink-UL memory endpoint sitting directly downstream of `rv64g_cache_system` on its `mem_a_*`/`mem_d_*` ports. It is the synthesizable replacement for the behavioural RAM responder used in system simulation. It accepts Get, PutFullData and PutPartialData requests, including multi-beat cache-line bursts. It returns AccessAckData bursts or single-beat AccessAck responses with full A/D ready/valid backpressure, out of an internal word-addressed RAM.

## Interface
- `ADDR_W`, 64: A-channel address width.
- `DATA_W`, 64: beat width; fixed at 64 (8-byte mask).
- `SRC_W`, 4: source ID width.
- `DEPTH`, 1024: RAM depth in 64-bit words (8 KiB); power of two.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `a_opcode_i` in 3: 0=PutFullData, 1=PutPartialData, 4=Get.
- `a_param_i` in 3: ignored.
- `a_size_i` in 3: log2 bytes; 0..6.
- `a_source_i` in SRC_W: requester ID.
- `a_address_i` in ADDR_W: byte address.
- `a_mask_i` in 8: byte enables for Put beats.
- `a_data_i` in DATA_W: Put beat data.
- `a_valid_i` in 1 / `a_ready_o` out 1: A handshake.
- `d_opcode_o` out 3: 0=AccessAck, 1=AccessAckData.
- `d_param_o` out 2: always 0.
- `d_size_o` out 3: echo of the request size.
- `d_source_o` out SRC_W: echo of the request source.
- `d_sink_o` out 2: always 0.
- `d_denied_o` out 1: address out of range, or opcode not supported.
- `d_data_o` out DATA_W: response beat data.
- `d_corrupt_o` out 1: set only together with `d_denied_o` on AccessAckData.
- `d_valid_o` out 1 / `d_ready_i` in 1: D handshake.

## Operation
- Beat count: `beats = (size<=3) ? 1 : 1<<(size-3)`, giving 1, 2, 4 or 8.
- Word index: `widx = address[3 +: log2(DEPTH)]`.
- Beat k addresses `widx` with its low `log2(beats)` bits replaced by `(widx_low + k) mod beats`. Bursts wrap within their naturally aligned block.
- Denied when `address >> 3 >= DEPTH`, or when the opcode is not 0, 1 or 4. A denied request never writes the RAM. Its read data is 0.
- State machine:
  - IDLE: `a_ready_o=1`.
    - Get accepted: latch source, size, base and denied; load beat 0; go to RD.
    - Put accepted: write beat 0 under mask unless denied. Go to WR if `beats>1`, else ACK.
    - Unsupported opcode: single beat, go to ACK with denied.
  - WR: `a_ready_o=1`. Each accepted beat writes the next wrapped word under `a_mask_i`. Opcode, size, source and address on later beats are ignored. The last beat goes to ACK.
  - RD: `a_ready_o=0`, `d_valid_o=1`, opcode 1. On each D handshake the next beat is loaded. The last handshake goes to IDLE.
  - ACK: `a_ready_o=0`, `d_valid_o=1`, opcode 0. The handshake goes to IDLE.
- PutFullData and PutPartialData behave identically: the mask is always honoured.
- RAM contents are not cleared by reset. Simulation init value: word i = i.
- A write is visible to any Get accepted in a later cycle.

## Timing
- Reset values:
  - `a_ready_o`=1 (IDLE state).
  - `d_valid_o`, `d_opcode_o`, `d_param_o`, `d_size_o`, `d_source_o`, `d_sink_o`, `d_denied_o`, `d_corrupt_o`, `d_data_o`: all 0.
- `a_ready_o` is a combinational decode of the state only. It does not depend on `a_valid_i` or `d_ready_i`.
- All D outputs are registered. They stay stable while `d_valid_o && !d_ready_i`.
- Get accepted in cycle N:
  - Beat 0 valid in N+1.
  - With `d_ready_i`=1 throughout, beats occupy N+1..N+beats.
  - `a_ready_o`=1 again in N+beats+1.
- Put final beat accepted in cycle M: AccessAck valid in M+1. If `d_ready_i`=1, `a_ready_o`=1 in M+2.
- WR with `a_valid_i` low: the block waits indefinitely, with no timeout.
- Reset asserted mid-burst: returns to IDLE immediately and drops `d_valid_o`. RAM words already written are retained. The partial burst is abandoned with no response.

## Test plan
- Reset, then Get addr 0x100 size 6 source 2, `d_ready_i`=1:
  - 8 beats with opcode 1, source 2, size 6.
  - Data 0x20..0x27 on consecutive cycles.
  - `a_ready_o`=0 for the 8 beat cycles.
- Get addr 0x118 size 6: wrapped data order 0x23..0x27, then 0x20..0x22.
- PutFullData 8 beats at 0x100, data 0xDEADBEEF+k, mask 0xFF:
  - One AccessAck one cycle after the last beat.
  - A following Get of 0x100 returns 0xDEADBEEF..0xDEADBEEF+7.
- PutPartialData size 3 at 0x40, mask 0x0F, data 0xAAAAAAAA_BBBBBBBB:
  - Get of 0x40 size 3 returns 0x00000000_BBBBBBBB (old word 8 upper bytes are 0).
- Get addr 0x2000: 8 beats, data 0, `d_denied_o`=1, `d_corrupt_o`=1. A Put to 0x2000 gets a denied AccessAck and RAM is unchanged.
- Get size 6 with `d_ready_i` toggled 1,0,0,1 per cycle: data held during stalls, all 8 beats delivered in order. Then `rst_ni` asserted after beat 3 of a new burst: `d_valid_o`=0 and `a_ready_o`=1 immediately.
